// File: rtl/stream_demux_buf.sv
// -----------------------------------------------------------------------------
// stream_demux_buf
//
// Registered 1-to-NCH stream demultiplexer. A single producer presents one
// item (in_data) together with a destination index (in_sel). The item is
// placed in the one-entry output register of that channel. Each channel then
// drains to its own consumer independently, one cycle after acceptance.
//
// Optional feature (macro STREAM_DEMUX_BCAST_EN):
//   Adds input bcast. A broadcast item ignores in_sel. It is accepted only
//   when every channel can take it, and it then loads every channel.
//
// Parameters:
//   DW   data width in bits (>= 1)
//   NCH  number of output channels (>= 2, any value)
//   SW   select width, derived as max(1, clog2(NCH))
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   producer has an item
//   in_ready   item is accepted this cycle (combinational)
//   in_data    item payload, DW bits
//   in_sel     destination channel index, SW bits
//   bcast      (macro builds only) load the item into every channel
//   out_valid  bit k: channel k holds an item
//   out_ready  bit k: consumer k takes the item this cycle
//   out_data   channel k payload at bits [k*DW +: DW]
//   err_sel    one-cycle pulse after an item with in_sel >= NCH is dropped
// -----------------------------------------------------------------------------
module stream_demux_buf #(
    parameter int DW  = 8,
    parameter int NCH = 8,
    localparam int SW = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    input  logic [SW-1:0]       in_sel,
`ifdef STREAM_DEMUX_BCAST_EN
    input  logic                bcast,
`endif
    output logic [NCH-1:0]      out_valid,
    input  logic [NCH-1:0]      out_ready,
    output logic [NCH*DW-1:0]   out_data,
    output logic                err_sel
);

    logic [NCH-1:0]          full_r;
    logic [NCH-1:0][DW-1:0]  data_r;
    logic                    err_r;

    logic [NCH-1:0]          sel_hit_s;
    logic [NCH-1:0]          chan_free_s;
    logic [NCH-1:0]          load_s;
    logic                    sel_ok_s;
    logic                    bcast_s;
    logic                    accept_s;
    logic                    err_next_s;

    // Broadcast request, only meaningful while an item is offered.
`ifdef STREAM_DEMUX_BCAST_EN
    assign bcast_s = in_valid & bcast;
`else
    assign bcast_s = 1'b0;
`endif

    // Per-channel decode: which channel is addressed and which can take an item.
    // The loop compare keeps out-of-range selects from indexing past NCH.
    always_comb begin
        sel_hit_s   = '0;
        chan_free_s = '0;
        for (int k = 0; k < NCH; k++) begin
            sel_hit_s[k]   = (in_sel == SW'(k));
            chan_free_s[k] = ~full_r[k] | out_ready[k];
        end
    end

    // NCH always fits in SW+1 bits, so this unsigned compare is exact.
    assign sel_ok_s = ({1'b0, in_sel} < (SW + 1)'(NCH));

    // Handshake. An invalid select is always accepted so that it can be dropped.
    always_comb begin
        if (!rst_n) begin
            in_ready = 1'b0;
        end else if (bcast_s) begin
            in_ready = &chan_free_s;
        end else if (sel_ok_s) begin
            in_ready = |(sel_hit_s & chan_free_s);
        end else begin
            in_ready = 1'b1;
        end
    end

    assign accept_s = in_valid & in_ready;

    // Slot load enables and the drop flag for the next cycle.
    always_comb begin
        load_s     = '0;
        err_next_s = 1'b0;
        if (!accept_s) begin
            load_s     = '0;
            err_next_s = 1'b0;
        end else if (bcast_s) begin
            load_s     = '1;
            err_next_s = 1'b0;
        end else begin
            load_s     = sel_hit_s;
            err_next_s = ~sel_ok_s;
        end
    end

    // Slot state. A load wins over a concurrent pop, which gives one item per cycle per channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_r <= '0;
            data_r <= '0;
            err_r  <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (load_s[k]) begin
                    full_r[k] <= 1'b1;
                    data_r[k] <= in_data;
                end else if (full_r[k] & out_ready[k]) begin
                    full_r[k] <= 1'b0;
                end else begin
                    full_r[k] <= full_r[k];
                end
            end
            err_r <= err_next_s;
        end
    end

    assign out_valid = full_r;
    assign out_data  = data_r;
    assign err_sel   = err_r;

endmodule

// File: tb/tb_stream_demux_buf.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_buf
//
// Directed bench for stream_demux_buf. It has two instances:
//   dut  : DW=8, NCH=8 (routing, backpressure, back-to-back, reset, broadcast)
//   dut6 : DW=8, NCH=6 (invalid select / err_sel)
//
// Each accepted item is pushed into the expected queue of its destination
// channel. A separate monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_stream_demux_buf;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [63:0] out_data;
    logic        err_sel;
    logic        bcast;

    logic        in_valid6;
    logic        in_ready6;
    logic [7:0]  in_data6;
    logic [2:0]  in_sel6;
    logic [5:0]  out_valid6;
    logic [5:0]  out_ready6;
    logic [47:0] out_data6;
    logic        err_sel6;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [8][$];

    always #5 clk = ~clk;

    stream_demux_buf #(.DW(8), .NCH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
`ifdef STREAM_DEMUX_BCAST_EN
        .bcast     (bcast),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_sel   (err_sel)
    );

    stream_demux_buf #(.DW(8), .NCH(6)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid6),
        .in_ready  (in_ready6),
        .in_data   (in_data6),
        .in_sel    (in_sel6),
`ifdef STREAM_DEMUX_BCAST_EN
        .bcast     (1'b0),
`endif
        .out_valid (out_valid6),
        .out_ready (out_ready6),
        .out_data  (out_data6),
        .err_sel   (err_sel6)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: each channel handshake must match the oldest expected item.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 8; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("unexpected_ch%0d", k), {56'd0, out_data[k*8 +: 8]}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        chk($sformatf("data_ch%0d", k), {56'd0, out_data[k*8 +: 8]}, {56'd0, exp_q[k].pop_front()});
                    end
                end
            end
        end
    end

    // Watchdog so that the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_sel     = 3'd0;
        out_ready  = 8'h00;
        bcast      = 1'b0;
        in_valid6  = 1'b0;
        in_data6   = 8'h00;
        in_sel6    = 3'd0;
        out_ready6 = 6'h3F;
        tick();
        tick();
        rst_n = 1'b1;

        // ---- Reset: load two slots, then assert reset for two edges ----
        in_valid = 1'b1; in_sel = 3'd1; in_data = 8'h77;
        tick();
        in_sel = 3'd4; in_data = 8'h88;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("preload_valid", {56'd0, out_valid}, 64'h12);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b1; in_sel = 3'd0; in_data = 8'h99;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        tick();
        @(negedge clk);
        chk("rst_out_valid", {56'd0, out_valid}, 64'h00);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_err_sel", {63'd0, err_sel}, 64'd0);
        chk("rst_in_ready2", {63'd0, in_ready}, 64'd0);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // ---- Routing sweep: one item per channel, one per cycle ----
        out_ready = 8'hFF;
        for (int j = 0; j <= 8; j++) begin
            if (j < 8) begin
                in_valid = 1'b1; in_sel = 3'(j); in_data = 8'hA0 + 8'(j);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (j > 0) chk("sweep_onehot", {56'd0, out_valid}, 64'(1) << (j - 1));
            if (j < 8) begin
                chk("sweep_ready", {63'd0, in_ready}, 64'd1);
                exp_q[j].push_back(8'hA0 + 8'(j));
            end
            tick();
        end
        @(negedge clk);
        chk("sweep_empty", {56'd0, out_valid}, 64'h00);
        tick();

        // ---- Backpressure on channel 3 ----
        out_ready = 8'hF7;
        in_valid = 1'b1; in_sel = 3'd3; in_data = 8'h11;
        @(negedge clk);
        chk("bp_first_ready", {63'd0, in_ready}, 64'd1);
        exp_q[3].push_back(8'h11);
        tick();
        in_data = 8'h22;
        @(negedge clk);
        chk("bp_stall", {63'd0, in_ready}, 64'd0);
        chk("bp_hold_data", {56'd0, out_data[31:24]}, 64'h11);
        tick();
        in_sel = 3'd5; in_data = 8'h33;
        @(negedge clk);
        chk("bp_other_ready", {63'd0, in_ready}, 64'd1);
        exp_q[5].push_back(8'h33);
        tick();
        in_sel = 3'd3; in_data = 8'h22; out_ready = 8'hFF;
        @(negedge clk);
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        exp_q[3].push_back(8'h22);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_swap_valid", {63'd0, out_valid[3]}, 64'd1);
        chk("bp_swap_data", {56'd0, out_data[31:24]}, 64'h22);
        tick();

        // ---- Back-to-back on channel 2 ----
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_sel = 3'd2; in_data = 8'(i);
            @(negedge clk);
            chk("b2b_ready", {63'd0, in_ready}, 64'd1);
            if (i > 1) chk("b2b_data", {56'd0, out_data[23:16]}, 64'(i - 1));
            exp_q[2].push_back(8'(i));
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last", {56'd0, out_data[23:16]}, 64'd4);
        tick();

        // ---- Invalid select on the 6-channel instance ----
        in_valid6 = 1'b1; in_sel6 = 3'd6; in_data6 = 8'hE6;
        @(negedge clk);
        chk("inv6_ready", {63'd0, in_ready6}, 64'd1);
        tick();
        in_sel6 = 3'd7; in_data6 = 8'hE7;
        @(negedge clk);
        chk("inv7_ready", {63'd0, in_ready6}, 64'd1);
        chk("inv_err1", {63'd0, err_sel6}, 64'd1);
        chk("inv_valid1", {58'd0, out_valid6}, 64'd0);
        tick();
        in_sel6 = 3'd5; in_data6 = 8'h55;
        @(negedge clk);
        chk("inv_err2", {63'd0, err_sel6}, 64'd1);
        chk("inv_valid2", {58'd0, out_valid6}, 64'd0);
        tick();
        in_valid6 = 1'b0;
        @(negedge clk);
        chk("inv_err_clear", {63'd0, err_sel6}, 64'd0);
        chk("nch6_valid5", {58'd0, out_valid6}, 64'h20);
        chk("nch6_data5", {56'd0, out_data6[47:40]}, 64'h55);
        tick();
        @(negedge clk);
        chk("nch6_drained", {58'd0, out_valid6}, 64'd0);
        tick();

`ifdef STREAM_DEMUX_BCAST_EN
        // ---- Broadcast stalls on a blocked channel 0, then fills all ----
        out_ready = 8'hFE;
        in_valid = 1'b1; in_sel = 3'd0; in_data = 8'h01;
        @(negedge clk);
        exp_q[0].push_back(8'h01);
        tick();
        bcast = 1'b1; in_sel = 3'd6; in_data = 8'h5A;
        @(negedge clk);
        chk("bc_stall", {63'd0, in_ready}, 64'd0);
        tick();
        out_ready = 8'hFF;
        @(negedge clk);
        chk("bc_ready", {63'd0, in_ready}, 64'd1);
        for (int k = 0; k < 8; k++) exp_q[k].push_back(8'h5A);
        tick();
        in_valid = 1'b0; bcast = 1'b0;
        @(negedge clk);
        chk("bc_all_valid", {56'd0, out_valid}, 64'hFF);
        chk("bc_no_err", {63'd0, err_sel}, 64'd0);
        tick();
`endif

        // ---- Drain and final bookkeeping ----
        out_ready = 8'hFF;
        tick();
        tick();
        @(negedge clk);
        chk("end_valid", {56'd0, out_valid}, 64'h00);
        chk("end_err", {63'd0, err_sel}, 64'd0);
        for (int k = 0; k < 8; k++) chk($sformatf("leftover_ch%0d", k), 64'(exp_q[k].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
